// File: rtl/switch_pkg.sv
// Shared types and helpers for the pushbutton write-strobe conditioner.
package switch_pkg;

    localparam int unsigned ADDR_WIDTH = 16;
    localparam logic [ADDR_WIDTH-1:0] DEFAULT_VGA_CONTROL_ADDRESS = 16'h0002;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        HELD = 1'b1
    } switch_state_e;

    // Width of a counter that must hold values 0 .. n-1; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/switch_debounce.sv
// One-bit input conditioner: multi-flop synchronizer followed by a stability counter.
module switch_debounce
    import switch_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 120000,
    parameter logic        RESET_VALUE     = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic raw_i,
    output logic stable_o
);

    localparam int unsigned CNT_W = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   synced;
    logic                   stable_q, stable_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;

    assign synced   = sync_q[SYNC_STAGES-1];
    assign stable_o = stable_q;

    // Synchronizer chain; bit 0 is the metastability-exposed stage.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= {SYNC_STAGES{RESET_VALUE}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw_i};
        end
    end

    // Accept a change only after it has persisted for DEBOUNCE_CYCLES cycles.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = cnt_q;
        if (synced == stable_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            stable_d = synced;
            cnt_d    = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stable_q <= RESET_VALUE;
            cnt_q    <= '0;
        end else begin
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/switch_write_strobe.sv
// Pushbutton-driven register write: one strobe per debounced press with a DIP snapshot.
// Define SWITCH_AUTO_REPEAT_EN to add auto-repeat strobes while the button is held.
module switch_write_strobe
    import switch_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 120000,
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DATA_WIDTH      = 8,
    parameter logic [ADDR_WIDTH-1:0] WRITE_ADDRESS = DEFAULT_VGA_CONTROL_ADDRESS
`ifdef SWITCH_AUTO_REPEAT_EN
    ,
    parameter int unsigned REPEAT_DELAY    = 6000000,
    parameter int unsigned REPEAT_PERIOD   = 1200000
`endif
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  button_n,
    input  logic [DATA_WIDTH-1:0] dip,
    output logic                  write_enable,
    output logic [ADDR_WIDTH-1:0] write_address,
    output logic [ADDR_WIDTH-1:0] data_out,
    output logic                  pressed
);

    logic                  btn_stable_n;
    logic                  btn_down;
    logic [DATA_WIDTH-1:0] dip_sync_q [SYNC_STAGES];
    logic [DATA_WIDTH-1:0] dip_synced;

    switch_state_e         state_q, state_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] data_q, data_d;
    logic                  pressed_q, pressed_d;

`ifdef SWITCH_AUTO_REPEAT_EN
    localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned RPT_W   = cnt_width(RPT_MAX);
    localparam logic [RPT_W-1:0] DELAY_LAST  = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);

    logic [RPT_W-1:0] rpt_q, rpt_d;
    logic             first_q, first_d;
`endif

    switch_debounce #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .RESET_VALUE    (1'b1)
    ) u_button (
        .clk     (clk),
        .reset   (reset),
        .raw_i   (button_n),
        .stable_o(btn_stable_n)
    );

    assign btn_down   = ~btn_stable_n;
    assign dip_synced = dip_sync_q[SYNC_STAGES-1];

    // DIP lines are only synchronized; they are sampled at strobe time.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
                dip_sync_q[i] <= '0;
            end
        end else begin
            dip_sync_q[0] <= dip;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                dip_sync_q[i] <= dip_sync_q[i-1];
            end
        end
    end

    // Press/release tracker; the strobe fires on the IDLE->HELD transition.
    always_comb begin
        state_d   = state_q;
        we_d      = 1'b0;
        data_d    = data_q;
        pressed_d = btn_down;
`ifdef SWITCH_AUTO_REPEAT_EN
        rpt_d     = rpt_q;
        first_d   = first_q;
`endif
        case (state_q)
            IDLE: begin
                if (btn_down) begin
                    state_d = HELD;
                    we_d    = 1'b1;
                    data_d  = ADDR_WIDTH'(dip_synced);
`ifdef SWITCH_AUTO_REPEAT_EN
                    rpt_d   = '0;
                    first_d = 1'b1;
`endif
                end
            end
            HELD: begin
                if (!btn_down) begin
                    state_d = IDLE;
`ifdef SWITCH_AUTO_REPEAT_EN
                    rpt_d   = '0;
                    first_d = 1'b1;
                end else if (rpt_q == (first_q ? DELAY_LAST : PERIOD_LAST)) begin
                    we_d    = 1'b1;
                    data_d  = ADDR_WIDTH'(dip_synced);
                    rpt_d   = '0;
                    first_d = 1'b0;
                end else begin
                    rpt_d   = rpt_q + RPT_W'(1);
`endif
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            we_q      <= 1'b0;
            data_q    <= '0;
            pressed_q <= 1'b0;
`ifdef SWITCH_AUTO_REPEAT_EN
            rpt_q     <= '0;
            first_q   <= 1'b1;
`endif
        end else begin
            state_q   <= state_d;
            we_q      <= we_d;
            data_q    <= data_d;
            pressed_q <= pressed_d;
`ifdef SWITCH_AUTO_REPEAT_EN
            rpt_q     <= rpt_d;
            first_q   <= first_d;
`endif
        end
    end

    assign write_enable  = we_q;
    assign data_out      = data_q;
    assign pressed       = pressed_q;
    assign write_address = WRITE_ADDRESS;

endmodule

// File: tb/tb_switch_write_strobe.sv
// Self-checking bench for switch_write_strobe (short debounce; SWITCH_AUTO_REPEAT_EN aware).
module tb_switch_write_strobe;

    localparam int unsigned DEB  = 4;
    localparam int unsigned SYNC = 2;
    localparam int unsigned DW   = 8;
    localparam int          LAT  = SYNC + DEB;
    localparam int          RPT_DELAY  = 10;
    localparam int          RPT_PERIOD = 5;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          button_n = 1'b1;
    logic [DW-1:0] dip = '0;
    logic          write_enable;
    logic [15:0]   write_address;
    logic [15:0]   data_out;
    logic          pressed;

    int cyc = 0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        int          cyc;
        logic [15:0] data;
    } exp_t;
    exp_t sb_q[$];

    typedef struct {
        logic [7:0]  dip;
        int          low_len;
        int          high_len;
        logic [15:0] exp_data;
    } vec_t;
    vec_t vecs[6];

    switch_write_strobe #(
        .DEBOUNCE_CYCLES(DEB),
        .SYNC_STAGES    (SYNC),
        .DATA_WIDTH     (DW),
        .WRITE_ADDRESS  (16'h0002)
`ifdef SWITCH_AUTO_REPEAT_EN
        ,
        .REPEAT_DELAY   (RPT_DELAY),
        .REPEAT_PERIOD  (RPT_PERIOD)
`endif
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .button_n     (button_n),
        .dip          (dip),
        .write_enable (write_enable),
        .write_address(write_address),
        .data_out     (data_out),
        .pressed      (pressed)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Expected strobes for a press whose first low sample is at edge e0 and lasts low_len edges.
    task automatic push_press(input int e0, input int low_len, input logic [15:0] d);
        exp_t e;
        if (low_len >= int'(DEB)) begin
            e.cyc  = e0 + LAT;
            e.data = d;
            sb_q.push_back(e);
`ifdef SWITCH_AUTO_REPEAT_EN
            for (int t = e0 + LAT + RPT_DELAY; t <= e0 + low_len + LAT - 1; t += RPT_PERIOD) begin
                e.cyc = t;
                sb_q.push_back(e);
            end
`endif
        end
    endtask

    task automatic press(input logic [7:0] d, input int low_len, input int high_len);
        int e0;
        @(negedge clk);
        dip      = d;
        button_n = 1'b0;
        e0       = cyc + 1;
        push_press(e0, low_len, 16'(d));
        repeat (low_len) @(negedge clk);
        button_n = 1'b1;
        repeat (high_len) @(negedge clk);
    endtask

    // Scoreboard monitor: every strobe must match the head of the expected queue.
    always @(negedge clk) begin
        exp_t e;
        if (sb_q.size() != 0 && sb_q[0].cyc < cyc) begin
            checks++;
            errors++;
            $display("FAIL missed_strobe: got none expected strobe at cycle %0d", sb_q[0].cyc);
            void'(sb_q.pop_front());
        end
        if (write_enable === 1'b1) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_strobe: got write_enable=1 expected 0 at cycle %0d", cyc);
            end else begin
                e = sb_q.pop_front();
                check("strobe_cycle", 32'(cyc), 32'(e.cyc));
                check("strobe_data", 32'(data_out), 32'(e.data));
                check("strobe_pressed", 32'(pressed), 32'd1);
                check("strobe_addr", 32'(write_address), 32'h0002);
            end
        end
    end

    initial begin
        int e0;
        int r;

        vecs[0] = '{8'hA5, 12, 12, 16'h00A5};
        vecs[1] = '{8'h5A,  3, 10, 16'h00A5};
        vecs[2] = '{8'h3C,  4, 10, 16'h003C};
        vecs[3] = '{8'hFF, 50, 12, 16'h00FF};
        vecs[4] = '{8'h00,  1, 10, 16'h00FF};
        vecs[5] = '{8'h81, 30, 12, 16'h0081};

        repeat (3) @(negedge clk);
        check("reset_we", 32'(write_enable), 32'd0);
        check("reset_data", 32'(data_out), 32'd0);
        check("reset_pressed", 32'(pressed), 32'd0);
        check("reset_addr", 32'(write_address), 32'h0002);
        reset = 1'b0;
        repeat (5) @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            press(vecs[i].dip, vecs[i].low_len, vecs[i].high_len);
            check("vec_data_hold", 32'(data_out), 32'(vecs[i].exp_data));
            check("vec_released", 32'(pressed), 32'd0);
        end

        // Bounce: 3 low, 1 high, then a solid low.
        @(negedge clk);
        dip      = 8'h5A;
        button_n = 1'b0;
        repeat (3) @(negedge clk);
        button_n = 1'b1;
        @(negedge clk);
        button_n = 1'b0;
        push_press(cyc + 1, 20, 16'h005A);
        repeat (20) @(negedge clk);
        button_n = 1'b1;
        repeat (12) @(negedge clk);
        check("bounce_data", 32'(data_out), 32'h005A);

        // Long hold: pressed must fall exactly LAT edges after the release is first sampled.
        @(negedge clk);
        dip      = 8'h96;
        button_n = 1'b0;
        push_press(cyc + 1, 50, 16'h0096);
        repeat (50) @(negedge clk);
        button_n = 1'b1;
        r = cyc + 1;
        repeat (LAT) @(negedge clk);
        check("release_still_pressed", 32'(pressed), 32'd1);
        check("release_cycle_a", 32'(cyc), 32'(r + LAT - 1));
        @(negedge clk);
        check("release_fall", 32'(pressed), 32'd0);
        repeat (5) @(negedge clk);
        press(8'h3C, 8, 10);
        check("second_press_data", 32'(data_out), 32'h003C);

        // DIP changes around the strobe: the value sampled SYNC edges earlier is captured.
        @(negedge clk);
        dip      = 8'h11;
        button_n = 1'b0;
        e0       = cyc + 1;
        begin
            exp_t e;
            e.cyc  = e0 + LAT;
            e.data = 16'h0022;
            sb_q.push_back(e);
        end
        repeat (4) @(negedge clk);
        dip = 8'h22;
        @(negedge clk);
        dip = 8'h33;
        repeat (3) @(negedge clk);
        button_n = 1'b1;
        repeat (10) @(negedge clk);
        check("dip_edge_data", 32'(data_out), 32'h0022);

        // Reset two cycles into debounce.
        @(negedge clk);
        button_n = 1'b0;
        e0       = cyc + 1;
        repeat (4) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("rst_debounce_we", 32'(write_enable), 32'd0);
        check("rst_debounce_data", 32'(data_out), 32'd0);
        check("rst_debounce_pressed", 32'(pressed), 32'd0);
        @(negedge clk);
        button_n = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        check("post_reset_idle", 32'(pressed), 32'd0);

        // Reset while HELD, button kept down through reset release.
        @(negedge clk);
        dip      = 8'h77;
        button_n = 1'b0;
        e0       = cyc + 1;
        push_press(e0, 8, 16'h0077);
        repeat (9) @(negedge clk);
        check("held_before_reset", 32'(pressed), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("rst_held_we", 32'(write_enable), 32'd0);
        check("rst_held_data", 32'(data_out), 32'd0);
        check("rst_held_pressed", 32'(pressed), 32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        push_press(cyc + 1, 20, 16'h0077);
        repeat (20) @(negedge clk);
        button_n = 1'b1;
        repeat (12) @(negedge clk);
        check("held_reset_data", 32'(data_out), 32'h0077);
        check("held_reset_released", 32'(pressed), 32'd0);

        repeat (5) @(negedge clk);
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_pending: got %0d outstanding expected 0", sb_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/switch_write_strobe.md
Name: switch_write_strobe

Overview:
- Board-input conditioner upstream of the vga_device control write port on the ECP5 reference top.
- Replaces the raw `~SW2` level write enable and raw DIP data with debounced, synchronized inputs.
- Emits exactly one write_enable pulse per button press, with a registered DIP snapshot and a fixed target address.
- Also usable for any device register write driven from a pushbutton.

Parameters:
- DEBOUNCE_CYCLES, 120000, consecutive stable cycles needed to accept a button change (10 ms at 12 MHz); minimum 2.
- SYNC_STAGES, 2, flip-flop synchronizer depth on every raw input; minimum 2.
- DATA_WIDTH, 8, number of DIP inputs sampled.
- WRITE_ADDRESS, 16'h0002, constant driven on write_address.
- REPEAT_DELAY, 6000000, held cycles before first auto-repeat (optional feature only).
- REPEAT_PERIOD, 1200000, cycles between auto-repeats (optional feature only).

Ports:
- clk, input, 1: single clock.
- reset, input, 1: asynchronous, active-high reset.
- button_n, input, 1: raw pushbutton, active-low, asynchronous to clk.
- dip, input, DATA_WIDTH: raw DIP switches, asynchronous to clk.
- write_enable, output, 1: one-cycle write strobe.
- write_address, output, 16: always WRITE_ADDRESS.
- data_out, output, 16: DIP snapshot, zero-extended to 16 bits.
- pressed, output, 1: debounced button state, 1 = held.

Behaviour:
- **Reset values**
  - Outputs: write_enable=0, data_out=0, pressed=0.
  - Internal: synchronizer flops=1 for button and 0 for dip; debounce counter=0; stable button=released; FSM=IDLE.
- **Synchronizer**
  - button_n and each dip bit pass through SYNC_STAGES flops.
  - dip is not debounced; it is only sampled when write_enable fires.
- **Debounce**
  - Counter clears whenever the synced button equals the stable state.
  - Counter increments while they differ.
  - When the counter reaches DEBOUNCE_CYCLES-1 while still differing: stable <= synced, counter <= 0.
  - Any bounce back before that point clears the counter, so a glitch shorter than DEBOUNCE_CYCLES never changes stable.
- **FSM states**
  - IDLE: on a stable press edge, assert write_enable for one cycle; go to HELD.
  - HELD: on a stable release edge, go to IDLE. No further strobes in HELD unless the optional feature is enabled.
- **Latency**
  - First clk edge sampling button_n low = edge 0.
  - write_enable is high after edge SYNC_STAGES+DEBOUNCE_CYCLES.
  - write_enable stays high for exactly one cycle.
- **data_out**
  - Registered in the same cycle write_enable asserts, from the synced dip.
  - Upper 16-DATA_WIDTH bits are 0.
  - Holds until the next strobe.
- **pressed**
  - Equals the stable state.
  - Rises in the same cycle as the strobe and falls when the release is accepted.
- **Boundary conditions**
  - Button held through reset deassertion: treated as a new press; exactly one strobe after the normal latency.
  - Reset mid-debounce or mid-HELD: all state returns to reset values immediately; no strobe is emitted during reset.
  - DIP change on the same cycle as the strobe: captures the synced value present that cycle, i.e. the raw value from SYNC_STAGES cycles earlier.
  - Counter width: clog2(DEBOUNCE_CYCLES); it never wraps.

Optional Feature:
- Macro: SWITCH_AUTO_REPEAT_EN.
- Defined:
  - HELD adds a repeat counter, cleared on entry to HELD.
  - After REPEAT_DELAY cycles held, issue a strobe with a fresh DIP sample.
  - Thereafter issue a strobe every REPEAT_PERIOD cycles until release.
  - On release, the repeat counter clears and no strobe is issued.
- Undefined:
  - Exactly one strobe per press.
  - No repeat counter logic is synthesized.

Decomposition:
- Shared package switch_pkg holds:
  - the FSM state enum (IDLE, HELD);
  - DEFAULT_VGA_CONTROL_ADDRESS = 16'h0002;
  - a clog2-based counter width function.
- One sub-module, switch_debounce (synchronizer plus debounce counter, 1-bit):
  - instantiated once for the button;
  - reused elsewhere for other buttons.

Test Plan (bench uses DEBOUNCE_CYCLES=4, SYNC_STAGES=2; for the repeat test also REPEAT_DELAY=10, REPEAT_PERIOD=5):
- Clean press: dip=8'hA5, button_n low from edge 0 -> write_enable high only in the cycle after edge 6; data_out=16'h00A5; write_address=16'h0002; pressed=1.
- Bounce: button_n low for 3 cycles, high for 1, then low -> no strobe during the glitch; exactly one strobe, 6 edges after the final low is first sampled.
- Hold and release: hold for 50 cycles, then release -> a single strobe; pressed falls 6 edges after release; a second press yields a second strobe with new dip=8'h3C -> data_out=16'h003C.
- Reset mid-operation: assert reset 2 cycles into debounce -> write_enable=0, data_out=0, pressed=0 immediately.
- Held through reset: button held during reset, reset released -> one strobe after 6 edges, then none while held.
- SWITCH_AUTO_REPEAT_EN defined: hold 30 cycles -> strobes at the initial press, +10, +15, +20, +25 cycles; none after release.
